// File: rtl/demod_cfg_pkg.sv
// -----------------------------------------------------------------------------
// demod_cfg_pkg
// Shared definitions for the demodulation configuration register block:
// host word addresses, STATUS bit positions, CTRL field positions and the
// configuration record used for both the shadow and the active copy.
// -----------------------------------------------------------------------------
package demod_cfg_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 33;

   // Host word addresses
   localparam logic [ADDR_W-1:0] ADDR_CTRL       = 14'h000;
   localparam logic [ADDR_W-1:0] ADDR_NUM_PTS    = 14'h001;
   localparam logic [ADDR_W-1:0] ADDR_I_BIN      = 14'h002;
   localparam logic [ADDR_W-1:0] ADDR_Q_BIN      = 14'h003;
   localparam logic [ADDR_W-1:0] ADDR_BIN_MIN    = 14'h004;
   localparam logic [ADDR_W-1:0] ADDR_I_VEC_PERP = 14'h005;
   localparam logic [ADDR_W-1:0] ADDR_Q_VEC_PERP = 14'h006;
   localparam logic [ADDR_W-1:0] ADDR_I_PT_LINE  = 14'h007;
   localparam logic [ADDR_W-1:0] ADDR_Q_PT_LINE  = 14'h008;
   localparam logic [ADDR_W-1:0] ADDR_STATUS     = 14'h009;
   localparam logic [ADDR_W-1:0] ADDR_RESULT     = 14'h00A;
   localparam logic [ADDR_W-1:0] ADDR_COMMIT     = 14'h00B;

   // STATUS bit positions (count occupies the low bits)
   localparam int STAT_OVERFLOW = 16;
   localparam int STAT_PENDING  = 17;
   localparam int STAT_ADDR_ERR = 18;

   // CTRL field positions
   localparam int CTRL_MODE_LSB = 0;
   localparam int CTRL_OUT_MODE = 2;
   localparam int CTRL_CFG_RST  = 3;

   typedef struct packed {
      logic [1:0]  mode;
      logic        output_mode;
      logic [15:0] num_pts;
      logic [15:0] i_bin_width;
      logic [7:0]  i_bin_num;
      logic [15:0] q_bin_width;
      logic [7:0]  q_bin_num;
      logic [15:0] i_min;
      logic [15:0] q_min;
      logic [31:0] i_vec_perp;
      logic [31:0] q_vec_perp;
      logic [31:0] i_pt_line;
      logic [31:0] q_pt_line;
   } cfg_t;

   // Every address from CTRL through COMMIT is decoded; anything above is not.
   function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
      return (addr <= ADDR_COMMIT);
   endfunction

endpackage

// File: rtl/demod_cfg_regs_if.sv
// -----------------------------------------------------------------------------
// demod_cfg_regs_if
// Host PcPort memory bus: 14-bit word address, one-cycle read/write strobes,
// 33-bit write data (bit 32 unused) and 33-bit read data (bit 32 = valid).
//   master : host side, drives address/strobes/write data
//   slave  : register block side, drives read data
// -----------------------------------------------------------------------------
interface demod_cfg_regs_if;
   import demod_cfg_pkg::*;

   logic [ADDR_W-1:0] MEM_sdi_mem_S_address;
   logic              MEM_sdi_mem_S_rdEn;
   logic              MEM_sdi_mem_S_wrEn;
   logic [DATA_W-1:0] MEM_sdi_mem_S_wrData;
   logic [DATA_W-1:0] MEM_sdi_mem_M_rdData;

   modport master (
      output MEM_sdi_mem_S_address,
      output MEM_sdi_mem_S_rdEn,
      output MEM_sdi_mem_S_wrEn,
      output MEM_sdi_mem_S_wrData,
      input  MEM_sdi_mem_M_rdData
   );

   modport slave (
      input  MEM_sdi_mem_S_address,
      input  MEM_sdi_mem_S_rdEn,
      input  MEM_sdi_mem_S_wrEn,
      input  MEM_sdi_mem_S_wrData,
      output MEM_sdi_mem_M_rdData
   );

endinterface

// File: rtl/demod_result_fifo.sv
// -----------------------------------------------------------------------------
// demod_result_fifo
// Synchronous result FIFO with registered pop data.
//   push_i/push_data_i : store a word; dropped (drop_o) when full unless a pop
//                        frees a slot in the same cycle
//   pop_i              : pop request; rd_data_o/rd_valid_o update on the next
//                        edge and hold until the next pop request
//   full_o/empty_o/count_o : occupancy (count saturates at DEPTH)
// -----------------------------------------------------------------------------
module demod_result_fifo #(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [31:0]              push_data_i,
   input  logic                     pop_i,
   output logic [31:0]              rd_data_o,
   output logic                     rd_valid_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     drop_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      do_pop     = pop_i && !empty_o;
      // A pop on a full FIFO frees the slot the push lands in; an empty pop
      // never sees the same-cycle push (no fall-through).
      do_push    = push_i && (!full_o || do_pop);
      drop_o     = push_i && full_o && !do_pop;
      wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
      if (pop_i) begin
         rd_data_d  = do_pop ? mem_q[rd_ptr_q] : '0;
         rd_valid_d = do_pop;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // NOTE: the storage array is not reset; pointers and count define what is
   // valid, and leaving it reset-free lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign count_o    = count_q;

endmodule

// File: rtl/demod_cfg_regs.sv
// -----------------------------------------------------------------------------
// demod_cfg_regs
// Host-addressable configuration and result registers for the qubit
// demodulation path.
//   clk, rst_n    : clock, asynchronous active-low reset
//   mem (slave)   : PcPort memory bus, 1-cycle registered read latency
//   analyze_busy  : acquisition in progress; defers shadow->active commits
//   res_valid/res_data : result words pushed into the result FIFO
//   analyze_mode .. q_pt_line : active configuration
//   config_reset  : one-cycle pulse after a CTRL write with bit 3 set
// -----------------------------------------------------------------------------
module demod_cfg_regs
   import demod_cfg_pkg::*;
#(
   parameter int FIFO_DEPTH = 256,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   demod_cfg_regs_if.slave    mem,
   input  logic               analyze_busy,
   input  logic               res_valid,
   input  logic [31:0]        res_data,
   output logic [1:0]         analyze_mode,
   output logic               output_mode,
   output logic [15:0]        num_data_pts,
   output logic [15:0]        i_bin_width,
   output logic [15:0]        q_bin_width,
   output logic [7:0]         i_bin_num,
   output logic [7:0]         q_bin_num,
   output logic signed [15:0] i_min,
   output logic signed [15:0] q_min,
   output logic signed [31:0] i_vec_perp,
   output logic signed [31:0] q_vec_perp,
   output logic signed [31:0] i_pt_line,
   output logic signed [31:0] q_pt_line,
   output logic               config_reset
);

   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

   cfg_t              shadow_q, shadow_d;
   cfg_t              active_q, active_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              pop_sel_q, pop_sel_d;
   logic              pending_q, pending_d;
   logic              overflow_q, overflow_d;
   logic              addr_err_q, addr_err_d;
   logic              cfg_rst_q, cfg_rst_d;

   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              wr, rd, mapped, pop, commit_req, do_copy;
   logic [31:0]       status_word, rd_word;

   logic [31:0]           fifo_data;
   logic                  fifo_valid, fifo_full, fifo_empty, fifo_drop;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  unused_ok;

   assign addr      = mem.MEM_sdi_mem_S_address;
   assign wdata     = mem.MEM_sdi_mem_S_wrData[31:0];
   assign unused_ok = ^{mem.MEM_sdi_mem_S_wrData[32], fifo_full, fifo_empty};

   // A simultaneous read is dropped in favour of the write.
   assign wr     = mem.MEM_sdi_mem_S_wrEn;
   assign rd     = mem.MEM_sdi_mem_S_rdEn && !mem.MEM_sdi_mem_S_wrEn;
   assign mapped = is_mapped(addr);
   assign pop    = rd && (addr == ADDR_RESULT);

   demod_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (res_valid),
      .push_data_i (res_data),
      .pop_i       (pop),
      .rd_data_o   (fifo_data),
      .rd_valid_o  (fifo_valid),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .drop_o      (fifo_drop)
   );

   always_comb begin
      status_word                = '0;
      status_word[CNT_W-1:0]     = CNT_W'(fifo_count);
      status_word[STAT_OVERFLOW] = overflow_q;
      status_word[STAT_PENDING]  = pending_q;
      status_word[STAT_ADDR_ERR] = addr_err_q;
   end

   // Shadow read-back mux (shadow, not active, values are visible to the host)
   always_comb begin
      rd_word = '0;
      unique case (addr)
         ADDR_CTRL:       rd_word = {29'b0, shadow_q.output_mode, shadow_q.mode};
         ADDR_NUM_PTS:    rd_word = {16'b0, shadow_q.num_pts};
         ADDR_I_BIN:      rd_word = {8'b0, shadow_q.i_bin_num, shadow_q.i_bin_width};
         ADDR_Q_BIN:      rd_word = {8'b0, shadow_q.q_bin_num, shadow_q.q_bin_width};
         ADDR_BIN_MIN:    rd_word = {shadow_q.q_min, shadow_q.i_min};
         ADDR_I_VEC_PERP: rd_word = shadow_q.i_vec_perp;
         ADDR_Q_VEC_PERP: rd_word = shadow_q.q_vec_perp;
         ADDR_I_PT_LINE:  rd_word = shadow_q.i_pt_line;
         ADDR_Q_PT_LINE:  rd_word = shadow_q.q_pt_line;
         ADDR_STATUS:     rd_word = status_word;
         default:         rd_word = '0;
      endcase
   end

   always_comb begin
      shadow_d   = shadow_q;
      rd_d       = rd_q;
      pop_sel_d  = pop_sel_q;
      overflow_d = overflow_q;
      addr_err_d = addr_err_q;
      cfg_rst_d  = 1'b0;

      if (wr) begin
         unique case (addr)
            ADDR_CTRL: begin
               shadow_d.mode        = wdata[CTRL_MODE_LSB +: 2];
               shadow_d.output_mode = wdata[CTRL_OUT_MODE];
               cfg_rst_d            = wdata[CTRL_CFG_RST];
            end
            ADDR_NUM_PTS:    shadow_d.num_pts = wdata[15:0];
            ADDR_I_BIN: begin
               shadow_d.i_bin_width = wdata[15:0];
               shadow_d.i_bin_num   = wdata[23:16];
            end
            ADDR_Q_BIN: begin
               shadow_d.q_bin_width = wdata[15:0];
               shadow_d.q_bin_num   = wdata[23:16];
            end
            ADDR_BIN_MIN: begin
               shadow_d.i_min = wdata[15:0];
               shadow_d.q_min = wdata[31:16];
            end
            ADDR_I_VEC_PERP: shadow_d.i_vec_perp = wdata;
            ADDR_Q_VEC_PERP: shadow_d.q_vec_perp = wdata;
            ADDR_I_PT_LINE:  shadow_d.i_pt_line  = wdata;
            ADDR_Q_PT_LINE:  shadow_d.q_pt_line  = wdata;
            ADDR_STATUS: begin
               if (wdata[STAT_OVERFLOW]) overflow_d = 1'b0;
               if (wdata[STAT_ADDR_ERR]) addr_err_d = 1'b0;
            end
            default: ;
         endcase
      end

      if (rd) begin
         pop_sel_d = pop;
         rd_d      = mapped ? {1'b1, rd_word} : '0;
      end

      // New error/overflow events take priority over a same-cycle clear.
      if (fifo_drop) overflow_d = 1'b1;
      if (((wr || rd) && !mapped) || (mem.MEM_sdi_mem_S_rdEn && mem.MEM_sdi_mem_S_wrEn))
         addr_err_d = 1'b1;
   end

   // Commit: copy immediately when idle, otherwise hold a single pending
   // request until busy drops. shadow_d is copied so the newest values win.
   always_comb begin
      commit_req = wr && (addr == ADDR_COMMIT) && wdata[0];
      do_copy    = (commit_req || pending_q) && !analyze_busy;
      active_d   = do_copy ? shadow_d : active_q;
      pending_d  = pending_q;
      if (do_copy)         pending_d = 1'b0;
      else if (commit_req) pending_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q   <= '0;
         active_q   <= '0;
         rd_q       <= '0;
         pop_sel_q  <= 1'b0;
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
         addr_err_q <= 1'b0;
         cfg_rst_q  <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         rd_q       <= rd_d;
         pop_sel_q  <= pop_sel_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         addr_err_q <= addr_err_d;
         cfg_rst_q  <= cfg_rst_d;
      end
   end

   // A RESULT read is answered from the FIFO's own registered pop data; both
   // sources hold until the next read, so the host sees a stable word.
   assign mem.MEM_sdi_mem_M_rdData = pop_sel_q ? {fifo_valid, fifo_data} : rd_q;

   assign analyze_mode = active_q.mode;
   assign output_mode  = active_q.output_mode;
   assign num_data_pts = active_q.num_pts;
   assign i_bin_width  = active_q.i_bin_width;
   assign q_bin_width  = active_q.q_bin_width;
   assign i_bin_num    = active_q.i_bin_num;
   assign q_bin_num    = active_q.q_bin_num;
   assign i_min        = active_q.i_min;
   assign q_min        = active_q.q_min;
   assign i_vec_perp   = active_q.i_vec_perp;
   assign q_vec_perp   = active_q.q_vec_perp;
   assign i_pt_line    = active_q.i_pt_line;
   assign q_pt_line    = active_q.q_pt_line;
   assign config_reset = cfg_rst_q;

endmodule

// File: tb/tb_demod_cfg_regs.sv
// -----------------------------------------------------------------------------
// tb_demod_cfg_regs
// Directed bench for demod_cfg_regs (FIFO_DEPTH=256, CNT_W=16). Inputs are
// driven on the falling edge; outputs are sampled on a later falling edge.
// -----------------------------------------------------------------------------
module tb_demod_cfg_regs;
   import demod_cfg_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demod_cfg_regs_if bus ();

   logic               analyze_busy;
   logic               res_valid;
   logic [31:0]        res_data;
   logic [1:0]         analyze_mode;
   logic               output_mode;
   logic [15:0]        num_data_pts;
   logic [15:0]        i_bin_width, q_bin_width;
   logic [7:0]         i_bin_num, q_bin_num;
   logic signed [15:0] i_min, q_min;
   logic signed [31:0] i_vec_perp, q_vec_perp, i_pt_line, q_pt_line;
   logic               config_reset;

   demod_cfg_regs #(.FIFO_DEPTH(256), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem          (bus),
      .analyze_busy (analyze_busy),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .analyze_mode (analyze_mode),
      .output_mode  (output_mode),
      .num_data_pts (num_data_pts),
      .i_bin_width  (i_bin_width),
      .q_bin_width  (q_bin_width),
      .i_bin_num    (i_bin_num),
      .q_bin_num    (q_bin_num),
      .i_min        (i_min),
      .q_min        (q_min),
      .i_vec_perp   (i_vec_perp),
      .q_vec_perp   (q_vec_perp),
      .i_pt_line    (i_pt_line),
      .q_pt_line    (q_pt_line),
      .config_reset (config_reset)
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [13:0] a, input logic [32:0] d);
      @(negedge clk);
      bus.MEM_sdi_mem_S_address = a;
      bus.MEM_sdi_mem_S_wrData  = d;
      bus.MEM_sdi_mem_S_wrEn    = 1'b1;
      @(negedge clk);
      bus.MEM_sdi_mem_S_wrEn    = 1'b0;
   endtask

   task automatic bus_read(input logic [13:0] a, output logic [32:0] d);
      @(negedge clk);
      bus.MEM_sdi_mem_S_address = a;
      bus.MEM_sdi_mem_S_rdEn    = 1'b1;
      @(negedge clk);
      bus.MEM_sdi_mem_S_rdEn    = 1'b0;
      d = bus.MEM_sdi_mem_M_rdData;
   endtask

   initial begin
      logic [32:0] rdv;
      logic [32:0] exp_v;

      bus.MEM_sdi_mem_S_address = '0;
      bus.MEM_sdi_mem_S_rdEn    = 1'b0;
      bus.MEM_sdi_mem_S_wrEn    = 1'b0;
      bus.MEM_sdi_mem_S_wrData  = '0;
      analyze_busy = 1'b0;
      res_valid    = 1'b0;
      res_data     = '0;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("reset_rddata", bus.MEM_sdi_mem_M_rdData, 33'h0);
      check("reset_cfg_reset", 33'(config_reset), 33'h0);
      check("reset_num_pts", 33'(num_data_pts), 33'h0);
      rst_n = 1'b1;

      // ---- basic reads, unmapped access ----
      bus_read(ADDR_I_BIN, rdv);
      check("rd_i_bin_reset", rdv, 33'h1_0000_0000);
      bus_read(14'h3FF, rdv);
      check("rd_unmapped", rdv, 33'h0_0000_0000);
      bus_read(ADDR_STATUS, rdv);
      check("status_addr_err", rdv, 33'h1_0004_0000);
      bus_write(ADDR_STATUS, 33'h0_0004_0000);
      bus_read(ADDR_STATUS, rdv);
      check("status_w1c_addr_err", rdv, 33'h1_0000_0000);

      // ---- commit while idle ----
      bus_write(ADDR_I_BIN, 33'h0_0010_0040);
      bus_write(ADDR_BIN_MIN, 33'h0_FFF0_8000);
      bus_write(ADDR_I_VEC_PERP, 33'h0_DEAD_BEEF);
      bus_read(ADDR_I_BIN, rdv);
      check("rd_i_bin_shadow", rdv, 33'h1_0010_0040);
      check("i_bin_width_precommit", 33'(i_bin_width), 33'h0);
      bus_write(ADDR_COMMIT, 33'h1);
      check("i_bin_width_commit", 33'(i_bin_width), 33'h40);
      check("i_bin_num_commit", 33'(i_bin_num), 33'h10);
      check("i_min_commit", 33'($unsigned(i_min)), 33'h8000);
      check("q_min_commit", 33'($unsigned(q_min)), 33'hFFF0);
      check("i_vec_perp_commit", 33'($unsigned(i_vec_perp)), 33'h0_DEAD_BEEF);

      // ---- commit while busy, second commit absorbed, latest shadow wins ----
      analyze_busy = 1'b1;
      bus_write(ADDR_NUM_PTS, 33'd999);
      bus_write(ADDR_COMMIT, 33'h1);
      bus_write(ADDR_NUM_PTS, 33'd1000);
      bus_write(ADDR_COMMIT, 33'h1);
      check("num_pts_busy_hold", 33'(num_data_pts), 33'h0);
      bus_read(ADDR_STATUS, rdv);
      check("status_pending", rdv, 33'h1_0002_0000);
      @(negedge clk);
      analyze_busy = 1'b0;
      @(negedge clk);
      check("num_pts_after_busy", 33'(num_data_pts), 33'd1000);
      bus_read(ADDR_STATUS, rdv);
      check("status_pending_clr", rdv, 33'h1_0000_0000);

      // ---- fill FIFO past full ----
      for (int i = 0; i < 257; i++) begin
         @(negedge clk);
         res_valid = 1'b1;
         res_data  = 32'(i);
      end
      @(negedge clk);
      res_valid = 1'b0;
      bus_read(ADDR_STATUS, rdv);
      check("status_full_ovf", rdv, 33'h1_0001_0100);

      // ---- read/write collision: write wins, rdData held, addr_err set ----
      @(negedge clk);
      bus.MEM_sdi_mem_S_address = ADDR_NUM_PTS;
      bus.MEM_sdi_mem_S_wrData  = 33'd5;
      bus.MEM_sdi_mem_S_wrEn    = 1'b1;
      bus.MEM_sdi_mem_S_rdEn    = 1'b1;
      @(negedge clk);
      bus.MEM_sdi_mem_S_wrEn    = 1'b0;
      bus.MEM_sdi_mem_S_rdEn    = 1'b0;
      check("collision_rd_hold", bus.MEM_sdi_mem_M_rdData, 33'h1_0001_0100);
      bus_read(ADDR_STATUS, rdv);
      check("status_collision", rdv, 33'h1_0005_0100);
      bus_write(ADDR_STATUS, 33'h0_0005_0000);
      bus_read(ADDR_STATUS, rdv);
      check("status_w1c_both", rdv, 33'h1_0000_0100);
      bus_read(ADDR_NUM_PTS, rdv);
      check("collision_write_done", rdv, 33'h1_0000_0005);

      // ---- pops, refill, push+pop on full ----
      bus_read(ADDR_RESULT, rdv);
      check("pop0", rdv, 33'h1_0000_0000);
      bus_read(ADDR_RESULT, rdv);
      check("pop1", rdv, 33'h1_0000_0001);
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = 32'h300;
      @(negedge clk);
      res_data  = 32'h301;
      @(negedge clk);
      res_valid = 1'b0;
      bus_read(ADDR_STATUS, rdv);
      check("status_refull", rdv, 33'h1_0000_0100);
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = 32'hAA;
      bus.MEM_sdi_mem_S_address = ADDR_RESULT;
      bus.MEM_sdi_mem_S_rdEn    = 1'b1;
      @(negedge clk);
      res_valid = 1'b0;
      bus.MEM_sdi_mem_S_rdEn    = 1'b0;
      check("pushpop_full_data", bus.MEM_sdi_mem_M_rdData, 33'h1_0000_0002);
      bus_read(ADDR_STATUS, rdv);
      check("pushpop_full_count", rdv, 33'h1_0000_0100);

      // ---- drain: 3..255, then 0x300, 0x301, 0xAA ----
      for (int i = 0; i < 256; i++) begin
         if (i < 253)       exp_v = 33'h1_0000_0000 | 33'(i + 3);
         else if (i == 253) exp_v = 33'h1_0000_0300;
         else if (i == 254) exp_v = 33'h1_0000_0301;
         else               exp_v = 33'h1_0000_00AA;
         bus_read(ADDR_RESULT, rdv);
         check($sformatf("drain%0d", i), rdv, exp_v);
      end
      bus_read(ADDR_RESULT, rdv);
      check("pop_empty", rdv, 33'h0_0000_0000);
      bus_read(ADDR_STATUS, rdv);
      check("status_empty", rdv, 33'h1_0000_0000);

      // ---- push+pop on empty: no fall-through ----
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = 32'hBB;
      bus.MEM_sdi_mem_S_address = ADDR_RESULT;
      bus.MEM_sdi_mem_S_rdEn    = 1'b1;
      @(negedge clk);
      res_valid = 1'b0;
      bus.MEM_sdi_mem_S_rdEn    = 1'b0;
      check("pushpop_empty_data", bus.MEM_sdi_mem_M_rdData, 33'h0_0000_0000);
      bus_read(ADDR_STATUS, rdv);
      check("pushpop_empty_count", rdv, 33'h1_0000_0001);
      bus_read(ADDR_RESULT, rdv);
      check("pop_bb", rdv, 33'h1_0000_00BB);

      // ---- config_reset pulse, CTRL read-back, commit of CTRL ----
      @(negedge clk);
      bus.MEM_sdi_mem_S_address = ADDR_CTRL;
      bus.MEM_sdi_mem_S_wrData  = 33'hF;
      bus.MEM_sdi_mem_S_wrEn    = 1'b1;
      check("cfg_reset_before", 33'(config_reset), 33'h0);
      @(negedge clk);
      bus.MEM_sdi_mem_S_wrEn    = 1'b0;
      check("cfg_reset_pulse", 33'(config_reset), 33'h1);
      @(negedge clk);
      check("cfg_reset_one_cycle", 33'(config_reset), 33'h0);
      bus_read(ADDR_CTRL, rdv);
      check("rd_ctrl", rdv, 33'h1_0000_0007);
      check("mode_precommit", 33'(analyze_mode), 33'h0);
      bus_write(ADDR_COMMIT, 33'h1);
      check("mode_commit", 33'(analyze_mode), 33'h3);
      check("out_mode_commit", 33'(output_mode), 33'h1);
      check("num_pts_commit2", 33'(num_data_pts), 33'd5);

      // ---- asynchronous reset mid-stream ----
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = 32'h55;
      analyze_busy = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mode", 33'(analyze_mode), 33'h0);
      check("arst_out_mode", 33'(output_mode), 33'h0);
      check("arst_num_pts", 33'(num_data_pts), 33'h0);
      check("arst_i_bin_width", 33'(i_bin_width), 33'h0);
      check("arst_rddata", bus.MEM_sdi_mem_M_rdData, 33'h0);
      res_valid    = 1'b0;
      analyze_busy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus_read(ADDR_STATUS, rdv);
      check("arst_status", rdv, 33'h1_0000_0000);
      bus_read(ADDR_I_BIN, rdv);
      check("arst_shadow", rdv, 33'h1_0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/demod_cfg_regs.md
Name: demod_cfg_regs

Overview:
- Responder on the host PcPort memory interface (14-bit address, 33-bit data) for the qubit demodulation path.
- Holds shadow and active copies of every analyze/histogram/classification parameter. Commits shadow→active only while analysis is idle.
- Buffers analyze results in a FIFO that the host drains by reading a pop register.
- Replaces stream-embedded configuration with host-addressable registers.

Parameters:
- FIFO_DEPTH, 256, result FIFO entries; power of two, 2..1024.
- CNT_W, 16, width of the STATUS count field; must be ≥ log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- MEM_sdi_mem_S_address  in  14  word address.
- MEM_sdi_mem_S_rdEn  in  1  read strobe, one cycle per access.
- MEM_sdi_mem_S_wrEn  in  1  write strobe, one cycle per access.
- MEM_sdi_mem_S_wrData  in  33  write data; bit 32 ignored.
- MEM_sdi_mem_M_rdData  out  33  [31:0] read data; [32] read-valid.
- analyze_busy  in  1  analyze FSM mid-acquisition.
- res_valid  in  1  result word strobe.
- res_data  in  32  result word.
- analyze_mode  out  2  active config.
- output_mode  out  1  active config.
- num_data_pts  out  16  active config.
- i_bin_width, q_bin_width  out  16 each  active config.
- i_bin_num, q_bin_num  out  8 each  active config.
- i_min, q_min  out  16 each, signed  active config.
- i_vec_perp, q_vec_perp, i_pt_line, q_pt_line  out  32 each, signed  active config.
- config_reset  out  1  one-cycle pulse.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all shadow/active registers 0, rdData 0, config_reset 0, FIFO empty, sticky flags 0, commit_pending 0.
- Register map (word address):
  - 0x000 CTRL: [1:0] mode, [2] output_mode, [3] config_reset (write-1 pulse, reads 0).
  - 0x001 NUM_PTS: [15:0].
  - 0x002 I_BIN: [15:0] width, [23:16] num.
  - 0x003 Q_BIN: same layout as I_BIN.
  - 0x004 BIN_MIN: [15:0] i_min, [31:16] q_min.
  - 0x005..0x008: I_VEC_PERP, Q_VEC_PERP, I_PT_LINE, Q_PT_LINE.
  - 0x009 STATUS: [CNT_W-1:0] fifo count, [16] overflow, [17] commit_pending, [18] addr_err. Bits 16 and 18 are W1C; all other bits read-only.
  - 0x00A RESULT: read pops the FIFO.
  - 0x00B COMMIT: write bit0=1 requests a commit.
- Writes update shadow registers on the strobe cycle. Reads of 0x000..0x008 return shadow values, not active values.
- Read latency: exactly 1 cycle. rdData is registered and holds its value until the next read.
- rdData[32]:
  - 1 for mapped reads, and for a RESULT read with the FIFO non-empty.
  - 0 for an empty-FIFO pop (data 0) and for unmapped addresses (data 0; sets addr_err).
- rdEn and wrEn in the same cycle: the write executes, the read is ignored, rdData is unchanged, and addr_err is set.
- Unmapped write: ignored, sets addr_err.
- Commit:
  - If analyze_busy=0, active←shadow on the cycle after the COMMIT write.
  - If analyze_busy=1, commit_pending=1 and the copy happens on the first cycle analyze_busy=0, then pending clears.
  - A second COMMIT while pending is absorbed; a single copy is made using the latest shadow values.
- config_reset: a one-cycle pulse on the cycle after the CTRL write with [3]=1. It is independent of commit.
- FIFO push occurs on res_valid. Push when full: word dropped, overflow set.
- Push and pop in the same cycle:
  - Full: both occur, count unchanged.
  - Empty: push stored, pop returns invalid, no fall-through.
- count saturates at FIFO_DEPTH and zero-extends to CNT_W.
- Assertion of rst_n mid-acquisition clears the FIFO and all config immediately.

Decomposition:
- Package demod_cfg_pkg holds: address constants ADDR_CTRL..ADDR_COMMIT, STATUS bit indices, CTRL field positions, and a config record typedef (shadow and active share it).
- One sub-module, demod_result_fifo: synchronous FIFO with push, pop, full, empty, count, and registered read data.

Test Plan:
1. After reset, read 0x002 → rdData=0x1_0000_0000 one cycle later. Read 0x3FF → rdData[32]=0, STATUS[18]=1.
2. Write I_BIN=0x0010_0040, then COMMIT with analyze_busy=0 → next cycle i_bin_width=0x0040, i_bin_num=0x10.
3. Hold analyze_busy=1, write NUM_PTS=1000, then COMMIT → num_data_pts stays 0 and STATUS[17]=1. Drop busy → num_data_pts=1000 the same cycle+1, and STATUS[17]=0.
4. Push 257 results (value = index) with FIFO_DEPTH=256 → STATUS count=256, overflow=1. First RESULT read returns 0x1_0000_0000, second returns 0x1_0000_0001.
5. Write STATUS with 0x0005_0000 → bits 16 and 18 clear, count unchanged. RESULT read on an empty FIFO → rdData=0x0_0000_0000.
6. Write CTRL=0x8 → config_reset high for exactly 1 cycle. Assert rst_n low mid-stream → all outputs 0 asynchronously.
